// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory-port arbiter.
// Owner encoding doubles as the read-data routing select.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD_I = 2'd1,
        RD_D = 2'd2,
        WR_D = 2'd3
    } arb_state_e;

    localparam logic OWNER_I = 1'b0;
    localparam logic OWNER_D = 1'b1;

    localparam int unsigned DEF_BLOCK_BEATS = 16;

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-requester round-robin arbiter (bit 0 = I-cache, bit 1 = D-cache).
// The last-grant register moves only when the caller accepts the grant.
module rr_arbiter_2
    import mem_arb_pkg::*;
(
    input  logic       clk,
    input  logic       arst,
    input  logic [1:0] i_req,
    input  logic       i_accept,
    output logic [1:0] o_gnt
);

    logic r_last_d;

    always_comb begin
        o_gnt = i_req;
        // On contention the requester that was not served last wins.
        if (i_req == 2'b11) begin
            o_gnt = (r_last_d == OWNER_D) ? 2'b01 : 2'b10;
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_last_d <= OWNER_D;
        end else if (i_accept) begin
            r_last_d <= o_gnt[1];
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one AXI port between I-cache refills and D-cache write-back/refill.
// Define MEM_ARB_TIMEOUT_EN to add the watchdog abort that drives o_bus_error.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned BLOCK_BEATS    = DEF_BLOCK_BEATS,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic              clk,
    input  logic              arst,
    input  logic              i_i_req,
    input  logic [ADDR_W-1:0] i_i_addr,
    input  logic              i_d_rd_req,
    input  logic              i_d_wr_req,
    input  logic [ADDR_W-1:0] i_d_addr,
    input  logic              i_r_valid,
    input  logic              i_r_last,
    input  logic              i_b_resp,
    output logic              o_start_read,
    output logic              o_start_write,
    output logic [ADDR_W-1:0] o_axi_addr,
    output logic              o_owner,
    output logic              o_busy,
    output logic              o_i_done,
    output logic              o_d_done,
    output logic              o_beat_err,
    output logic              o_bus_error
);

    localparam int unsigned BEAT_W = $clog2(BLOCK_BEATS);

    if ((BLOCK_BEATS < 2) || (BLOCK_BEATS > 256) ||
        ((BLOCK_BEATS & (BLOCK_BEATS - 1)) != 0)) begin : g_bad_beats
        $error("BLOCK_BEATS must be a power of two in 2..256");
    end
    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 2");
    end

    arb_state_e        r_state;
    arb_state_e        w_state_nxt;
    logic [ADDR_W-1:0] r_addr;
    logic              r_owner;
    logic [BEAT_W-1:0] r_beat_cnt;
    logic              r_start_read;
    logic              r_start_write;
    logic              r_i_done;
    logic              r_d_done;
    logic              r_beat_err;

    logic              w_start_read_nxt;
    logic              w_start_write_nxt;
    logic              w_i_done_nxt;
    logic              w_d_done_nxt;
    logic              w_beat_err_set;
    logic              w_d_req;
    logic              w_arb_en;
    logic              w_grant;
    logic [1:0]        w_gnt;
    logic              w_to_abort;

    assign w_d_req  = i_d_rd_req | i_d_wr_req;
    // Hold off grants during the done cycle: the finished requester may still show its level.
    assign w_arb_en = (r_state == IDLE) && !r_i_done && !r_d_done;
    assign w_grant  = w_arb_en && (w_gnt != 2'b00);

    rr_arbiter_2 u_rr (
        .clk      (clk),
        .arst     (arst),
        .i_req    ({w_d_req, i_i_req}),
        .i_accept (w_grant),
        .o_gnt    (w_gnt)
    );

    always_comb begin
        w_state_nxt       = r_state;
        w_start_read_nxt  = 1'b0;
        w_start_write_nxt = 1'b0;
        w_i_done_nxt      = 1'b0;
        w_d_done_nxt      = 1'b0;
        w_beat_err_set    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_grant) begin
                    if (w_gnt[0]) begin
                        w_state_nxt      = RD_I;
                        w_start_read_nxt = 1'b1;
                    end else if (i_d_wr_req) begin
                        // Dirty eviction goes out before the refill of the same line.
                        w_state_nxt       = WR_D;
                        w_start_write_nxt = 1'b1;
                    end else begin
                        w_state_nxt      = RD_D;
                        w_start_read_nxt = 1'b1;
                    end
                end
            end
            RD_I, RD_D: begin
                if (i_r_valid && i_r_last) begin
                    w_beat_err_set = (r_beat_cnt != BEAT_W'(BLOCK_BEATS - 1));
                    w_i_done_nxt   = (r_state == RD_I);
                    w_d_done_nxt   = (r_state == RD_D);
                    w_state_nxt    = IDLE;
                end
            end
            WR_D: begin
                if (i_b_resp) begin
                    w_d_done_nxt = 1'b1;
                    w_state_nxt  = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
        if (w_to_abort) begin
            w_i_done_nxt = (r_owner == OWNER_I);
            w_d_done_nxt = (r_owner == OWNER_D);
            w_state_nxt  = IDLE;
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_addr        <= '0;
            r_owner       <= OWNER_I;
            r_beat_cnt    <= '0;
            r_start_read  <= 1'b0;
            r_start_write <= 1'b0;
            r_i_done      <= 1'b0;
            r_d_done      <= 1'b0;
            r_beat_err    <= 1'b0;
        end else begin
            r_start_read  <= w_start_read_nxt;
            r_start_write <= w_start_write_nxt;
            r_i_done      <= w_i_done_nxt;
            r_d_done      <= w_d_done_nxt;
            if (w_beat_err_set) begin
                r_beat_err <= 1'b1;
            end
            if (w_grant) begin
                r_addr     <= w_gnt[0] ? i_i_addr : i_d_addr;
                r_owner    <= w_gnt[0] ? OWNER_I : OWNER_D;
                r_beat_cnt <= '0;
            end else if (((r_state == RD_I) || (r_state == RD_D)) && i_r_valid) begin
                r_beat_cnt <= r_beat_cnt + BEAT_W'(1);
            end
        end
    end

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0] r_to_cnt;
    logic            r_bus_error;

    // Counts busy cycles without AXI progress; fires on the TIMEOUT_CYCLES-th such cycle.
    assign w_to_abort = (r_state != IDLE) && !i_r_valid && !i_b_resp &&
                        (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_to_cnt    <= '0;
            r_bus_error <= 1'b0;
        end else begin
            if ((r_state == IDLE) || i_r_valid || i_b_resp || w_to_abort) begin
                r_to_cnt <= '0;
            end else begin
                r_to_cnt <= r_to_cnt + TO_W'(1);
            end
            if (w_to_abort) begin
                r_bus_error <= 1'b1;
            end
        end
    end

    assign o_bus_error = r_bus_error;
`else
    assign w_to_abort  = 1'b0;
    assign o_bus_error = 1'b0;
`endif

    assign o_start_read  = r_start_read;
    assign o_start_write = r_start_write;
    assign o_axi_addr    = r_addr;
    assign o_owner       = r_owner;
    assign o_busy        = (r_state != IDLE);
    assign o_i_done      = r_i_done;
    assign o_d_done      = r_d_done;
    assign o_beat_err    = r_beat_err;

endmodule
